// File: rtl/el2_dccm_port_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// el2_dccm_port_arb - LSU/DMA arbiter for a single-port DCCM, zero-init on reset
// Revision: 1.0
// ---------------------------------------------------------------------------
module el2_dccm_port_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 39,
  parameter int STARVE_MAX = 4,
  parameter int INIT_EN    = 1,
  parameter int INIT_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_wr,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  output logic              lsu_req_ready,
  input  logic              dma_req_valid,
  input  logic              dma_req_wr,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_req_ready,
  output logic              dccm_wren,
  output logic              dccm_rden,
  output logic [ADDR_W-1:0] dccm_wr_addr_lo,
  output logic [ADDR_W-1:0] dccm_rd_addr_lo,
  output logic [DATA_W-1:0] dccm_wr_data_lo,
  input  logic [DATA_W-1:0] dccm_rd_data_lo,
  output logic              rd_valid_lsu,
  output logic              rd_valid_dma,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done
);

  localparam int               CNT_W      = $clog2(INIT_WORDS) + 1;
  localparam logic [0:0]       ST_INIT    = 1'b0;
  localparam logic [0:0]       ST_RUN     = 1'b1;
  localparam logic [0:0]       ST_RESET   = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WORDS - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             rd_valid_lsu_q, rd_valid_lsu_d;
  logic             rd_valid_dma_q, rd_valid_dma_d;
  logic             init_done_q, init_done_d;

  logic              run_act;
  logic              init_act;
  logic              lsu_gnt;
  logic              dma_gnt;
  logic [ADDR_W-1:0] init_addr;

  // Strobes and grants are gated by rst_l so nothing escapes while reset is held.
  assign run_act   = (state_q == ST_RUN) && rst_l;
  assign init_act  = (state_q == ST_INIT) && rst_l;
  assign dma_gnt   = run_act && dma_req_valid && (!lsu_req_valid || (starve_cnt_q == STARVE_LIM));
  assign lsu_gnt   = run_act && lsu_req_valid && !dma_gnt;
  assign init_addr = ADDR_W'({init_cnt_q, 2'b00});

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q        <= ST_RESET;
      init_cnt_q     <= '0;
      starve_cnt_q   <= '0;
      rd_valid_lsu_q <= 1'b0;
      rd_valid_dma_q <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
      rd_valid_lsu_q <= rd_valid_lsu_d;
      rd_valid_dma_q <= rd_valid_dma_d;
      init_done_q    <= init_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = '0;
    starve_cnt_d = '0;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + CNT_W'(1);
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      end
      default: begin
        // DMA still waiting means the LSU took this cycle; count it, saturating.
        if (dma_req_valid && !dma_gnt) begin
          starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
      end
    endcase
    init_done_d    = (state_d == ST_RUN);
    rd_valid_lsu_d = lsu_gnt && !lsu_req_wr;
    rd_valid_dma_d = dma_gnt && !dma_req_wr;
  end

  always_comb begin
    lsu_req_ready   = lsu_gnt;
    dma_req_ready   = dma_gnt;
    dccm_wren       = 1'b0;
    dccm_rden       = 1'b0;
    dccm_wr_addr_lo = '0;
    dccm_rd_addr_lo = '0;
    dccm_wr_data_lo = '0;
    if (init_act) begin
      dccm_wren       = 1'b1;
      dccm_wr_addr_lo = init_addr;
    end else if (lsu_gnt) begin
      if (lsu_req_wr) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = lsu_req_addr;
        dccm_wr_data_lo = lsu_req_wdata;
      end else begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = lsu_req_addr;
      end
    end else if (dma_gnt) begin
      if (dma_req_wr) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = dma_req_addr;
        dccm_wr_data_lo = dma_req_wdata;
      end else begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = dma_req_addr;
      end
    end
  end

  assign rd_valid_lsu = rd_valid_lsu_q;
  assign rd_valid_dma = rd_valid_dma_q;
  assign init_done    = init_done_q;
  assign rd_data      = dccm_rd_data_lo;

endmodule
`default_nettype wire

// File: tb/tb_el2_dccm_port_arb.sv
`default_nettype none
// Bench for el2_dccm_port_arb: fixed vectors, hand sequences and a randomized
// run against a request-level arbitration model.
module tb_el2_dccm_port_arb;
  localparam int AW = 16;
  localparam int DW = 39;
  localparam int SM = 3;
  localparam int IW = 8;
  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_L    = 2'd1;
  localparam logic [1:0] W_D    = 2'd2;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          lsu_req_valid, lsu_req_wr, dma_req_valid, dma_req_wr;
  logic [AW-1:0] lsu_req_addr, dma_req_addr;
  logic [DW-1:0] lsu_req_wdata, dma_req_wdata, dccm_rd_data_lo;

  logic          lsu_req_ready, dma_req_ready, dccm_wren, dccm_rden;
  logic [AW-1:0] dccm_wr_addr_lo, dccm_rd_addr_lo;
  logic [DW-1:0] dccm_wr_data_lo, rd_data;
  logic          rd_valid_lsu, rd_valid_dma, init_done;

  logic          n_lsu_ready, n_dma_ready, n_wren, n_rden;
  logic [AW-1:0] n_wr_addr, n_rd_addr;
  logic [DW-1:0] n_wr_data, n_rd_data;
  logic          n_rvl, n_rvd, n_init_done;

  el2_dccm_port_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .INIT_EN(1), .INIT_WORDS(IW)) dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wr(lsu_req_wr), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_ready(lsu_req_ready),
    .dma_req_valid(dma_req_valid), .dma_req_wr(dma_req_wr), .dma_req_addr(dma_req_addr),
    .dma_req_wdata(dma_req_wdata), .dma_req_ready(dma_req_ready),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden), .dccm_wr_addr_lo(dccm_wr_addr_lo),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_wr_data_lo(dccm_wr_data_lo),
    .dccm_rd_data_lo(dccm_rd_data_lo), .rd_valid_lsu(rd_valid_lsu), .rd_valid_dma(rd_valid_dma),
    .rd_data(rd_data), .init_done(init_done)
  );

  el2_dccm_port_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .INIT_EN(0), .INIT_WORDS(IW)) dut_noinit (
    .clk(clk), .rst_l(rst_l),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wr(lsu_req_wr), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_ready(n_lsu_ready),
    .dma_req_valid(dma_req_valid), .dma_req_wr(dma_req_wr), .dma_req_addr(dma_req_addr),
    .dma_req_wdata(dma_req_wdata), .dma_req_ready(n_dma_ready),
    .dccm_wren(n_wren), .dccm_rden(n_rden), .dccm_wr_addr_lo(n_wr_addr),
    .dccm_rd_addr_lo(n_rd_addr), .dccm_wr_data_lo(n_wr_data),
    .dccm_rd_data_lo(dccm_rd_data_lo), .rd_valid_lsu(n_rvl), .rd_valid_dma(n_rvd),
    .rd_data(n_rd_data), .init_done(n_init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          lv, lw;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          dv, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic [1:0]    win;
    logic          rvl, rvd;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lv, input logic lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic dv, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    lsu_req_valid = lv; lsu_req_wr = lw; lsu_req_addr = la; lsu_req_wdata = ld;
    dma_req_valid = dv; dma_req_wr = dw; dma_req_addr = da; dma_req_wdata = dd;
    dccm_rd_data_lo = {$urandom, $urandom};
  endtask

  // Expected DCCM-side behaviour follows directly from which requester wins.
  task automatic expect_outs(input string tag, input logic [1:0] win, input logic rvl, input logic rvd);
    logic          we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;
    if (win == W_L) begin
      if (lsu_req_wr) begin we = 1'b1; wa = lsu_req_addr; wd = lsu_req_wdata; end
      else begin re = 1'b1; ra = lsu_req_addr; end
    end else if (win == W_D) begin
      if (dma_req_wr) begin we = 1'b1; wa = dma_req_addr; wd = dma_req_wdata; end
      else begin re = 1'b1; ra = dma_req_addr; end
    end
    chk({tag, " lsu_ready"}, lsu_req_ready, win == W_L);
    chk({tag, " dma_ready"}, dma_req_ready, win == W_D);
    chk({tag, " wren"}, dccm_wren, we);
    chk({tag, " wr_addr"}, dccm_wr_addr_lo, wa);
    chk({tag, " wr_data"}, dccm_wr_data_lo, wd);
    chk({tag, " rden"}, dccm_rden, re);
    chk({tag, " rd_addr"}, dccm_rd_addr_lo, ra);
    chk({tag, " rd_valid_lsu"}, rd_valid_lsu, rvl);
    chk({tag, " rd_valid_dma"}, rd_valid_dma, rvd);
    chk({tag, " rd_data"}, rd_data, dccm_rd_data_lo);
  endtask

  // Called right after reset release on a falling edge; covers cycles 1..IW+1.
  task automatic check_init(input string tag, input bit with_noinit);
    for (int k = 0; k < IW; k++) begin
      #1;
      chk({tag, " init wren"}, dccm_wren, 1'b1);
      chk({tag, " init addr"}, dccm_wr_addr_lo, 64'(k * 4));
      chk({tag, " init data"}, dccm_wr_data_lo, 0);
      chk({tag, " init rden"}, dccm_rden, 1'b0);
      chk({tag, " init lsu_ready"}, lsu_req_ready, 1'b0);
      chk({tag, " init dma_ready"}, dma_req_ready, 1'b0);
      chk({tag, " init init_done"}, init_done, 1'b0);
      if (with_noinit) begin
        chk({tag, " noinit wren"}, n_wren, 1'b0);
        if (k < 2) chk({tag, " noinit init_done"}, n_init_done, k == 1);
      end
      @(negedge clk);
    end
    #1;
    chk({tag, " init_done rise"}, init_done, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, " wren"}, dccm_wren, 1'b0);
    chk({tag, " rden"}, dccm_rden, 1'b0);
    chk({tag, " lsu_ready"}, lsu_req_ready, 1'b0);
    chk({tag, " dma_ready"}, dma_req_ready, 1'b0);
    chk({tag, " rd_valid_lsu"}, rd_valid_lsu, 1'b0);
    chk({tag, " rd_valid_dma"}, rd_valid_dma, 1'b0);
    chk({tag, " init_done"}, init_done, 1'b0);
  endtask

  initial begin
    logic          pl_v, pl_w, pd_v, pd_w;
    logic [AW-1:0] pl_a, pd_a;
    logic [DW-1:0] pl_d, pd_d;
    logic [1:0]    win;
    logic          prev_lr, prev_dr;
    int            waits;

    tbl[0]  = '{1'b0, 1'b0, 16'h0,   39'h0,   1'b0, 1'b0, 16'h0,   39'h0,  W_NONE, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0,   39'h0,   1'b1, 1'b1, 16'h20,  39'h5A, W_D,    1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'h44,  39'h123, 1'b0, 1'b0, 16'h0,   39'h0,  W_L,    1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0,   39'h0,   1'b1, 1'b0, 16'h30,  39'h0,  W_D,    1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'h100, 39'h1,   1'b1, 1'b1, 16'h200, 39'h2,  W_L,    1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 16'h100, 39'h1,   1'b1, 1'b1, 16'h200, 39'h2,  W_L,    1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h100, 39'h1,   1'b1, 1'b1, 16'h200, 39'h2,  W_L,    1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 16'h100, 39'h1,   1'b1, 1'b1, 16'h200, 39'h2,  W_D,    1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'h104, 39'h3,   1'b1, 1'b1, 16'h204, 39'h4,  W_L,    1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'h108, 39'h5,   1'b1, 1'b1, 16'h204, 39'h4,  W_L,    1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'h10C, 39'h7,   1'b1, 1'b1, 16'h204, 39'h4,  W_L,    1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'h110, 39'h9,   1'b1, 1'b1, 16'h204, 39'h4,  W_D,    1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'h10,  39'h0,   1'b0, 1'b0, 16'h0,   39'h0,  W_L,    1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'h8,   39'h0,   1'b1, 1'b0, 16'hC,   39'h0,  W_L,    1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'h0,   39'h0,   1'b0, 1'b0, 16'h0,   39'h0,  W_NONE, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 16'h40,  39'hA,   1'b1, 1'b1, 16'h80,  39'hB,  W_L,    1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 16'h44,  39'hC,   1'b0, 1'b0, 16'h0,   39'h0,  W_L,    1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 16'h48,  39'hD,   1'b1, 1'b1, 16'h84,  39'hE,  W_L,    1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 16'h4C,  39'hD,   1'b1, 1'b1, 16'h84,  39'hE,  W_L,    1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 16'h50,  39'hD,   1'b1, 1'b1, 16'h84,  39'hE,  W_L,    1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 16'h54,  39'hD,   1'b1, 1'b1, 16'h84,  39'hE,  W_D,    1'b0, 1'b0};

    // Reset held with an LSU read pending; it must be held off, then granted.
    drive(1'b1, 1'b0, 16'h10, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outs("reset");
    chk("reset noinit lsu_ready", n_lsu_ready, 1'b0);
    chk("reset noinit rden", n_rden, 1'b0);
    chk("reset noinit init_done", n_init_done, 1'b0);
    @(negedge clk);
    rst_l = 1'b1;
    check_init("init", 1'b1);
    chk("first read lsu_ready", lsu_req_ready, 1'b1);
    chk("first read rden", dccm_rden, 1'b1);
    chk("first read rd_addr", dccm_rd_addr_lo, 16'h10);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    dccm_rd_data_lo = 39'h51_2345_6789;
    #1;
    chk("first read rd_valid_lsu", rd_valid_lsu, 1'b1);
    chk("first read rd_data", rd_data, 39'h51_2345_6789);
    chk("first read rd_valid_dma", rd_valid_dma, 1'b0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].lv, tbl[i].lw, tbl[i].la, tbl[i].ld, tbl[i].dv, tbl[i].dw, tbl[i].da, tbl[i].dd);
      #1;
      expect_outs($sformatf("vec%0d", i), tbl[i].win, tbl[i].rvl, tbl[i].rvd);
    end

    // Randomized run; requests are held until granted, as a real master would.
    pl_v = 1'b0; pd_v = 1'b0; pl_w = 1'b0; pd_w = 1'b0;
    pl_a = '0; pd_a = '0; pl_d = '0; pd_d = '0;
    prev_lr = 1'b0; prev_dr = 1'b0; waits = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!pl_v) begin
        pl_v = ($urandom_range(0, 3) != 0);
        pl_w = $urandom_range(0, 1) == 1;
        pl_a = AW'($urandom) & 16'hFFFC;
        pl_d = {$urandom, $urandom};
      end
      if (!pd_v) begin
        pd_v = ($urandom_range(0, 1) == 1);
        pd_w = $urandom_range(0, 1) == 1;
        pd_a = AW'($urandom) & 16'hFFFC;
        pd_d = {$urandom, $urandom};
      end
      drive(pl_v, pl_w, pl_a, pl_d, pd_v, pd_w, pd_a, pd_d);
      if (pd_v && (!pl_v || waits == SM)) win = W_D;
      else if (pl_v)                      win = W_L;
      else                                win = W_NONE;
      #1;
      expect_outs("rand", win, prev_lr, prev_dr);
      prev_lr = (win == W_L) && !pl_w;
      prev_dr = (win == W_D) && !pd_w;
      if (!pd_v || win == W_D) waits = 0;
      else if (waits < SM)     waits = waits + 1;
      if (win == W_L) pl_v = 1'b0;
      if (win == W_D) pd_v = 1'b0;
    end

    // Reset landing the cycle after a read grant must squash the read-valid.
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h10, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("pre-reset lsu_ready", lsu_req_ready, 1'b1);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    check_reset_outs("mid reset");

    // Reset pulsed part-way through init restarts the sweep from address 0.
    drive(1'b1, 1'b0, 16'h10, '0, 1'b1, 1'b1, 16'h20, 39'h5A);
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("partial init addr", dccm_wr_addr_lo, 64'(k * 4));
      chk("partial init wren", dccm_wren, 1'b1);
      @(negedge clk);
    end
    rst_l = 1'b0;
    #1;
    check_reset_outs("init pulse");
    @(negedge clk);
    rst_l = 1'b1;
    check_init("reinit", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/el2_dccm_port_arb.md
EL2_DCCM_PORT_ARB -- requirements
Module: el2_dccm_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, DCCM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 39, DCCM word width (32 data + 7 ECC).
REQ-003 SHALL have parameter STARVE_MAX, default 4, legal range 1-15; maximum consecutive LSU grants while DMA waits.
REQ-004 SHALL have parameter INIT_EN, default 1; 1 enables zero-init after reset.
REQ-005 SHALL have parameter INIT_WORDS, default 16384, legal range 2 to 2^(ADDR_W-2); number of words initialized.
REQ-006 SHALL have port clk, input, 1, core clock; the only clock.
REQ-007 SHALL have port rst_l, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have ports lsu_req_valid / lsu_req_wr / lsu_req_addr / lsu_req_wdata, inputs, 1 / 1 / ADDR_W / DATA_W; LSU request.
REQ-009 SHALL have port lsu_req_ready, output, 1; LSU request accepted this cycle.
REQ-010 SHALL have ports dma_req_valid / dma_req_wr / dma_req_addr / dma_req_wdata, inputs, 1 / 1 / ADDR_W / DATA_W; DMA request.
REQ-011 SHALL have port dma_req_ready, output, 1; DMA request accepted this cycle.
REQ-012 SHALL have ports dccm_wren / dccm_rden, outputs, 1 / 1; DCCM strobes.
REQ-013 SHALL have ports dccm_wr_addr_lo / dccm_rd_addr_lo, outputs, ADDR_W; DCCM addresses.
REQ-014 SHALL have port dccm_wr_data_lo, output, DATA_W; DCCM write data.
REQ-015 SHALL have port dccm_rd_data_lo, input, DATA_W; DCCM read data, valid one cycle after dccm_rden.
REQ-016 SHALL have ports rd_valid_lsu / rd_valid_dma, outputs, 1 / 1; read data return qualifiers.
REQ-017 SHALL have port rd_data, output, DATA_W; direct pass-through of dccm_rd_data_lo.
REQ-018 SHALL have port init_done, output, 1; high once initialization is complete.

Function
REQ-019 SHALL implement states INIT and RUN; reset enters INIT if INIT_EN=1, otherwise RUN.
REQ-020 In INIT: SHALL assert dccm_wren each cycle, with dccm_wr_addr_lo = init_cnt*4 (truncated to ADDR_W), dccm_wr_data_lo = 0, and dccm_rden = 0.
REQ-021 init_cnt SHALL be $clog2(INIT_WORDS)+1 bits wide, start at 0, and increment per cycle; after the write at INIT_WORDS-1, the FSM SHALL move to RUN next cycle.
REQ-022 In INIT: lsu_req_ready and dma_req_ready SHALL be 0, and requests SHALL be held off, not dropped.
REQ-023 init_done SHALL be 0 in INIT, 1 in RUN, and registered.
REQ-024 In RUN: exactly one requester SHALL be granted per cycle, and only if valid; ready = grant, combinational from valid.
REQ-025 Default priority SHALL be LSU; DMA SHALL win if LSU is not valid, or if starve_cnt == STARVE_MAX and dma_req_valid.
REQ-026 starve_cnt SHALL increment when dma_req_valid and LSU is granted, clear when DMA is granted or dma_req_valid = 0, and saturate at STARVE_MAX.
REQ-027 Granted write: dccm_wren = 1, with addr/wdata from the winner, same cycle.
REQ-028 Granted read: dccm_rden = 1 and dccm_rd_addr_lo = winner address, same cycle.
REQ-029 rd_valid_lsu / rd_valid_dma SHALL be registered: 1 the cycle after a granted read by that requester, else 0.
REQ-030 Unused address/data outputs SHALL be driven 0 when the corresponding strobe is 0.
REQ-031 No request SHALL be buffered; an ungranted requester SHALL hold its request stable until ready.

Reset
REQ-032 While rst_l=0: all strobes, readies, rd_valid_*, init_done, init_cnt and starve_cnt SHALL be 0; state = INIT (INIT_EN=1) or RUN.
REQ-033 Reset asserted mid-INIT SHALL restart initialization from address 0 after deassertion.
REQ-034 Reset asserted the cycle after a read grant SHALL force rd_valid_* to 0.

Verification
REQ-035 INIT_WORDS=8, INIT_EN=1, release reset: the bench SHALL check 8 writes to addresses 0x0,0x4..0x1C with data 0; init_done=1 in cycle 9; readies 0 throughout.
REQ-036 STARVE_MAX=3, both valid continuously, writes: the bench SHALL check the grant sequence L,L,L,D,L,L,L,D.
REQ-037 LSU read addr 0x10 in cycle N: the bench SHALL check dccm_rden=1 with rd_addr 0x10 in N, and rd_valid_lsu=1 with rd_data = dccm_rd_data_lo in N+1.
REQ-038 DMA write alone (addr 0x20, data 0x5A): the bench SHALL check dma_req_ready=1 and dccm_wren=1 with addr 0x20 and data 0x5A in the same cycle.
REQ-039 INIT_WORDS=8, reset pulsed after 4 init writes: the bench SHALL check that writes restart at 0x0 and init_done rises 9 cycles after deassertion.
REQ-040 INIT_EN=0: the bench SHALL check init_done=1 one cycle after reset deassertion, with no init writes.
